// File: rtl/mlo_layer_sequencer.sv
// Per-frame layer scheduler: accepts a frame index, issues one weight-fetch command per layer,
// waits for each layer-complete token, then forwards the finished frame index downstream.
module mlo_layer_sequencer #(
  parameter int                   N_MAX_LAYERS   = 16,
  parameter int                   ADDR_BITS      = 64,
  parameter int                   CNT_BITS       = 16,
  parameter logic [ADDR_BITS-1:0] ADDR_INT       = '0,
  parameter logic [ADDR_BITS-1:0] LAYER_OFFS_INT = '0
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [CNT_BITS-1:0]  n_layers,
  input  logic [CNT_BITS-1:0]  s_idx_tdata,
  input  logic                 s_idx_tvalid,
  output logic                 s_idx_tready,
  output logic [CNT_BITS-1:0]  m_cmd_layer,
  output logic [ADDR_BITS-1:0] m_cmd_addr,
  output logic                 m_cmd_last,
  output logic                 m_cmd_tvalid,
  input  logic                 m_cmd_tready,
  input  logic                 s_ldone_tvalid,
  output logic                 s_ldone_tready,
  output logic [CNT_BITS-1:0]  m_idx_tdata,
  output logic                 m_idx_tvalid,
  input  logic                 m_idx_tready,
  output logic [1:0]           done_if,
  output logic                 busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_OUT  = 2'd3;

  localparam logic [CNT_BITS-1:0] MAX_EFF = CNT_BITS'(N_MAX_LAYERS);

  logic [1:0]           state_q, state_d;
  logic                 run_q;
  logic [CNT_BITS-1:0]  idx_q, idx_d;
  logic [CNT_BITS-1:0]  last_layer_q, last_layer_d;
  logic [CNT_BITS-1:0]  layer_q, layer_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;

  logic [CNT_BITS-1:0]  eff;
  logic                 cmd_is_last;
  logic                 idx_hs, cmd_hs, ldone_hs, out_hs;

  assign eff         = (n_layers > MAX_EFF) ? MAX_EFF : n_layers;
  assign cmd_is_last = (layer_q == last_layer_q);

  // run_q keeps s_idx_tready low while reset is asserted, even though the state reads IDLE.
  assign s_idx_tready   = run_q && (state_q == ST_IDLE);
  assign m_cmd_tvalid   = (state_q == ST_CMD);
  assign m_cmd_layer    = layer_q;
  assign m_cmd_addr     = addr_q;
  assign m_cmd_last     = m_cmd_tvalid && cmd_is_last;
  assign s_ldone_tready = (state_q == ST_WAIT);
  assign m_idx_tvalid   = (state_q == ST_OUT);
  assign m_idx_tdata    = idx_q;
  assign busy           = (state_q != ST_IDLE);

  assign idx_hs   = s_idx_tvalid   && s_idx_tready;
  assign cmd_hs   = m_cmd_tvalid   && m_cmd_tready;
  assign ldone_hs = s_ldone_tvalid && s_ldone_tready;
  assign out_hs   = m_idx_tvalid   && m_idx_tready;
  assign done_if  = {out_hs, ldone_hs};

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
    state_d      = state_q;
    idx_d        = idx_q;
    last_layer_d = last_layer_q;
    layer_d      = layer_q;
    addr_d       = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (idx_hs) begin
          idx_d        = s_idx_tdata;
          last_layer_d = eff - CNT_BITS'(1);
          layer_d      = '0;
          addr_d       = ADDR_INT;
          state_d      = (eff == '0) ? ST_OUT : ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_hs) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (ldone_hs) begin
          if (cmd_is_last) begin
            state_d = ST_OUT;
          end else begin
            layer_d = layer_q + CNT_BITS'(1);
            addr_d  = addr_q + LAYER_OFFS_INT;
            state_d = ST_CMD;
          end
        end
      end
      ST_OUT: begin
        if (out_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      idx_q        <= '0;
      last_layer_q <= '0;
      layer_q      <= '0;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      idx_q        <= idx_d;
      last_layer_q <= last_layer_d;
      layer_q      <= layer_d;
      addr_q       <= addr_d;
    end
  end

endmodule

// File: tb/tb_mlo_layer_sequencer.sv
// Self-checking bench for mlo_layer_sequencer: directed and randomized frames checked against
// an arithmetic reference (addr = base + k*stride, eff = min(n, max)), plus an 8-bit wrap instance.
module tb_mlo_layer_sequencer;

  localparam int          NMAX   = 16;
  localparam logic [63:0] A_INT  = 64'h1000;
  localparam logic [63:0] A_OFFS = 64'h200;
  localparam logic [7:0]  B_INT  = 8'hF0;
  localparam logic [7:0]  B_OFFS = 8'h20;

  logic aclk    = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [15:0] n_layers, s_idx_tdata, m_cmd_layer, m_idx_tdata;
  logic [63:0] m_cmd_addr;
  logic        s_idx_tvalid, s_idx_tready, m_cmd_last, m_cmd_tvalid, m_cmd_tready;
  logic        s_ldone_tvalid, s_ldone_tready, m_idx_tvalid, m_idx_tready, busy;
  logic [1:0]  done_if;

  logic [15:0] b_n_layers, b_s_idx_tdata, b_m_cmd_layer, b_m_idx_tdata;
  logic [7:0]  b_m_cmd_addr;
  logic        b_s_idx_tvalid, b_s_idx_tready, b_m_cmd_last, b_m_cmd_tvalid, b_m_cmd_tready;
  logic        b_s_ldone_tvalid, b_s_ldone_tready, b_m_idx_tvalid, b_m_idx_tready, b_busy;
  logic [1:0]  b_done_if;

  int checks = 0;
  int errors = 0;

  mlo_layer_sequencer #(
    .N_MAX_LAYERS(NMAX), .ADDR_BITS(64), .CNT_BITS(16),
    .ADDR_INT(A_INT), .LAYER_OFFS_INT(A_OFFS)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .n_layers(n_layers),
    .s_idx_tdata(s_idx_tdata), .s_idx_tvalid(s_idx_tvalid), .s_idx_tready(s_idx_tready),
    .m_cmd_layer(m_cmd_layer), .m_cmd_addr(m_cmd_addr), .m_cmd_last(m_cmd_last),
    .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
    .s_ldone_tvalid(s_ldone_tvalid), .s_ldone_tready(s_ldone_tready),
    .m_idx_tdata(m_idx_tdata), .m_idx_tvalid(m_idx_tvalid), .m_idx_tready(m_idx_tready),
    .done_if(done_if), .busy(busy)
  );

  mlo_layer_sequencer #(
    .N_MAX_LAYERS(NMAX), .ADDR_BITS(8), .CNT_BITS(16),
    .ADDR_INT(B_INT), .LAYER_OFFS_INT(B_OFFS)
  ) dut_wrap (
    .aclk(aclk), .aresetn(aresetn), .n_layers(b_n_layers),
    .s_idx_tdata(b_s_idx_tdata), .s_idx_tvalid(b_s_idx_tvalid), .s_idx_tready(b_s_idx_tready),
    .m_cmd_layer(b_m_cmd_layer), .m_cmd_addr(b_m_cmd_addr), .m_cmd_last(b_m_cmd_last),
    .m_cmd_tvalid(b_m_cmd_tvalid), .m_cmd_tready(b_m_cmd_tready),
    .s_ldone_tvalid(b_s_ldone_tvalid), .s_ldone_tready(b_s_ldone_tready),
    .m_idx_tdata(b_m_idx_tdata), .m_idx_tvalid(b_m_idx_tvalid), .m_idx_tready(b_m_idx_tready),
    .done_if(b_done_if), .busy(b_busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_idx_tready"},   s_idx_tready, 0);
    check({tag, "_m_cmd_tvalid"},   m_cmd_tvalid, 0);
    check({tag, "_m_cmd_layer"},    m_cmd_layer, 0);
    check({tag, "_m_cmd_addr"},     m_cmd_addr, 0);
    check({tag, "_m_cmd_last"},     m_cmd_last, 0);
    check({tag, "_s_ldone_tready"}, s_ldone_tready, 0);
    check({tag, "_m_idx_tvalid"},   m_idx_tvalid, 0);
    check({tag, "_m_idx_tdata"},    m_idx_tdata, 0);
    check({tag, "_done_if"},        done_if, 0);
    check({tag, "_busy"},           busy, 0);
  endtask

  // Runs one frame on the main instance and checks it against the reference rules.
  // early: ldone is held high from accept so it is offered before each command handshake.
  // abort_k: apply reset in the WAIT phase of this layer (-1 = never).
  task automatic run_frame(input logic [15:0] idx, input logic [15:0] n, input int smin,
                           input int smax, input bit early, input bit chg_n, input int abort_k);
    logic [15:0] eff;
    logic [63:0] exp_addr;
    int          guard;
    int          s;
    eff = (n > 16'(NMAX)) ? 16'(NMAX) : n;
    s_idx_tdata  = idx;
    n_layers     = n;
    s_idx_tvalid = 1'b1;
    guard = 0;
    @(negedge aclk);
    while (!s_idx_tready && guard < 20) begin
      tick();
      @(negedge aclk);
      guard++;
    end
    check("idx_accept_ready", s_idx_tready, 1);
    if (!s_idx_tready) begin
      s_idx_tvalid = 1'b0;
      return;
    end
    tick();
    s_idx_tvalid = 1'b0;
    s_idx_tdata  = 16'($urandom);
    if (chg_n) n_layers = 16'($urandom_range(40, 0));
    if (early) s_ldone_tvalid = 1'b1;

    for (int k = 0; k < int'(eff); k++) begin
      exp_addr = A_INT + A_OFFS * 64'(k);
      s = $urandom_range(smax, smin);
      m_cmd_tready = 1'b0;
      for (int j = 0; j < s; j++) begin
        @(negedge aclk);
        check("stall_cmd_valid", m_cmd_tvalid, 1);
        check("stall_cmd_layer", m_cmd_layer, 64'(k));
        check("stall_cmd_addr",  m_cmd_addr, exp_addr);
        check("stall_cmd_last",  m_cmd_last, (k == int'(eff) - 1));
        check("stall_ldone_not_ready", s_ldone_tready, 0);
        check("stall_no_pulse", done_if, 0);
        check("stall_idx_blocked", s_idx_tready, 0);
        tick();
      end
      m_cmd_tready = 1'b1;
      @(negedge aclk);
      check("cmd_valid", m_cmd_tvalid, 1);
      check("cmd_layer", m_cmd_layer, 64'(k));
      check("cmd_addr",  m_cmd_addr, exp_addr);
      check("cmd_last",  m_cmd_last, (k == int'(eff) - 1));
      check("cmd_busy",  busy, 1);
      tick();
      m_cmd_tready = 1'b0;

      if (!early) begin
        s = $urandom_range(smax, smin);
        for (int j = 0; j < s; j++) begin
          @(negedge aclk);
          check("wait_ldone_ready", s_ldone_tready, 1);
          check("wait_cmd_idle", m_cmd_tvalid, 0);
          check("wait_no_pulse", done_if, 0);
          tick();
        end
      end
      if (abort_k == k) begin
        s_idx_tvalid = 1'b1; s_ldone_tvalid = 1'b1; m_idx_tready = 1'b1; m_cmd_tready = 1'b1;
        aresetn = 1'b0;
        #1;
        check_all_zero("abort");
        tick();
        tick();
        s_idx_tvalid = 1'b0; s_ldone_tvalid = 1'b0; m_idx_tready = 1'b0; m_cmd_tready = 1'b0;
        aresetn = 1'b1;
        @(negedge aclk);
        check("post_abort_no_pulse", done_if, 0);
        check("post_abort_no_idx", m_idx_tvalid, 0);
        check("post_abort_idle", busy, 0);
        tick();
        return;
      end
      s_ldone_tvalid = 1'b1;
      @(negedge aclk);
      check("ldone_ready", s_ldone_tready, 1);
      check("ldone_pulse", done_if, 2'b01);
      tick();
      if (!early) s_ldone_tvalid = 1'b0;
    end

    s = $urandom_range(smax, smin);
    m_idx_tready = 1'b0;
    for (int j = 0; j < s; j++) begin
      @(negedge aclk);
      check("out_stall_valid", m_idx_tvalid, 1);
      check("out_stall_data", m_idx_tdata, idx);
      check("out_stall_no_cmd", m_cmd_tvalid, 0);
      check("out_stall_idx_blocked", s_idx_tready, 0);
      check("out_stall_ldone_held", s_ldone_tready, 0);
      check("out_stall_no_pulse", done_if, 0);
      tick();
    end
    m_idx_tready = 1'b1;
    @(negedge aclk);
    check("out_valid", m_idx_tvalid, 1);
    check("out_data", m_idx_tdata, idx);
    check("out_pulse", done_if, 2'b10);
    tick();
    m_idx_tready   = 1'b0;
    s_ldone_tvalid = 1'b0;
    @(negedge aclk);
    check("idle_after_out", busy, 0);
    check("idle_ready", s_idx_tready, 1);
    tick();
  endtask

  initial begin
    logic [7:0] b_exp;
    int         guard;
    n_layers = '0; s_idx_tdata = '0; s_idx_tvalid = 0; m_cmd_tready = 0;
    s_ldone_tvalid = 0; m_idx_tready = 0;
    b_n_layers = '0; b_s_idx_tdata = '0; b_s_idx_tvalid = 0; b_m_cmd_tready = 0;
    b_s_ldone_tvalid = 0; b_m_idx_tready = 0;

    #12;
    check_all_zero("reset");
    tick();
    aresetn = 1'b1;
    tick();

    run_frame(16'd7, 16'd3, 2, 2, 1'b0, 1'b0, -1);
    run_frame(16'd5, 16'd0, 0, 0, 1'b0, 1'b0, -1);
    run_frame(16'h00A5, 16'd20, 0, 1, 1'b0, 1'b0, -1);
    run_frame(16'd11, 16'd4, 4, 4, 1'b1, 1'b1, -1);
    run_frame(16'd12, 16'd3, 0, 1, 1'b0, 1'b0, 1);
    run_frame(16'd9, 16'd1, 0, 0, 1'b0, 1'b0, -1);

    for (int f = 0; f < 10; f++) begin
      run_frame(16'($urandom), 16'($urandom_range(20, 0)), 0, 3,
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), -1);
    end

    b_n_layers = 16'd2; b_s_idx_tdata = 16'd3; b_s_idx_tvalid = 1'b1;
    guard = 0;
    @(negedge aclk);
    while (!b_s_idx_tready && guard < 20) begin
      tick();
      @(negedge aclk);
      guard++;
    end
    check("wrap_accept_ready", b_s_idx_tready, 1);
    tick();
    b_s_idx_tvalid = 1'b0; b_m_cmd_tready = 1'b1; b_s_ldone_tvalid = 1'b1; b_m_idx_tready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      b_exp = B_INT + B_OFFS * 8'(k);
      @(negedge aclk);
      check("wrap_cmd_valid", b_m_cmd_tvalid, 1);
      check("wrap_cmd_layer", b_m_cmd_layer, 64'(k));
      check("wrap_cmd_addr", b_m_cmd_addr, b_exp);
      check("wrap_cmd_last", b_m_cmd_last, (k == 1));
      tick();
      @(negedge aclk);
      check("wrap_ldone_pulse", b_done_if, 2'b01);
      tick();
    end
    @(negedge aclk);
    check("wrap_out_valid", b_m_idx_tvalid, 1);
    check("wrap_out_data", b_m_idx_tdata, 3);
    check("wrap_out_pulse", b_done_if, 2'b10);
    tick();
    b_m_cmd_tready = 1'b0; b_s_ldone_tvalid = 1'b0; b_m_idx_tready = 1'b0;
    @(negedge aclk);
    check("wrap_idle", b_busy, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
